// File: rtl/load_store_unit_if.sv
// Handshake and memory-bus bundles for load_store_unit.
// lsu_req_if: core <-> LSU request/response; lsu_bus_if: LSU <-> data memory.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_funct3,
    output req_address, req_store_data,
    input  req_ready, resp_valid, resp_data, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_address, req_store_data,
    output req_ready, resp_valid, resp_data, resp_fault
  );
endinterface

interface lsu_bus_if;
  logic [31:0] bus_address;
  logic [31:0] bus_read_data;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;

  modport master (
    output bus_address, bus_write_data, bus_byte_enable,
    output bus_read_enable, bus_write_enable,
    input  bus_read_data
  );

  modport slave (
    input  bus_address, bus_write_data, bus_byte_enable,
    input  bus_read_enable, bus_write_enable,
    output bus_read_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: aligns, splits and merges accesses onto a word bus.
// Ports: clock, reset (sync, active-high), req (lsu_req_if.slave), bus (lsu_bus_if.master).
`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h1000_0000
`endif
`ifndef DATA_END
`define DATA_END 32'h1000_FFFF
`endif

module load_store_unit #(
  parameter logic [31:0] DATA_BEGIN = `DATA_BEGIN,
  parameter logic [31:0] DATA_END   = `DATA_END
) (
  input  logic      clock,
  input  logic      reset,
  lsu_req_if.slave  req,
  lsu_bus_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_LO,
    ISSUE_HI,
    RESP
  } state_t;

  state_t      r_state;
  logic        r_write;
  logic        r_fault;
  logic        r_split;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_hi_addr;
  logic [3:0]  r_hi_be;
  logic [31:0] r_hi_wdata;
  logic [31:0] r_lo_data;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_re;
  logic        r_we;

  logic [2:0]  w_size;
  logic [3:0]  w_smask;
  logic        w_legal;
  logic [32:0] w_last;
  logic        w_ovf;
  logic        w_oor;
  logic        w_fault;
  logic [1:0]  w_off;
  logic        w_split;
  logic [7:0]  w_mask8;
  logic [63:0] w_sdata64;
  logic [31:0] w_lo_addr;
  logic [31:0] w_lo_word;
  logic [31:0] w_hi_word;
  logic [63:0] w_shift64;
  logic [31:0] w_ld;
  logic        w_resp;

  // Request decode, only consumed on the accept edge.
  always_comb begin
    w_size  = 3'd4;
    w_smask = 4'b1111;
    unique case (req.req_funct3[1:0])
      2'b00: begin
        w_size  = 3'd1;
        w_smask = 4'b0001;
      end
      2'b01: begin
        w_size  = 3'd2;
        w_smask = 4'b0011;
      end
      default: begin
        w_size  = 3'd4;
        w_smask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    unique case (1'b1)
      req.req_write:
        w_legal = req.req_funct3 inside {3'd0, 3'd1, 3'd2};
      default:
        w_legal = req.req_funct3 inside
          {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endcase
  end

  // Address of the last byte, with a carry bit to catch wrap-around.
  assign w_last = {1'b0, req.req_address}
                + {30'd0, w_size} - 33'd1;
  assign w_ovf  = w_last[32];
  assign w_oor  = (req.req_address < DATA_BEGIN)
               || (w_last[31:0] > DATA_END);
  assign w_fault = !w_legal || w_ovf || w_oor;

  assign w_off     = req.req_address[1:0];
  assign w_split   = ({1'b0, w_off} + w_size) > 3'd4;
  assign w_mask8   = {4'b0000, w_smask} << w_off;
  assign w_sdata64 = {32'd0, req.req_store_data}
                   << {w_off, 3'b000};
  assign w_lo_addr = {req.req_address[31:2], 2'b00};

  // Load merge: low word captured earlier when split.
  assign w_lo_word = r_split ? r_lo_data : bus.bus_read_data;
  assign w_hi_word = r_split ? bus.bus_read_data : 32'd0;
  assign w_shift64 = {w_hi_word, w_lo_word} >> {r_off, 3'b000};

  always_comb begin
    w_ld = w_shift64[31:0];
    unique case (r_f3[1:0])
      2'b00:
        w_ld = {{24{~r_f3[2] & w_shift64[7]}},
                w_shift64[7:0]};
      2'b01:
        w_ld = {{16{~r_f3[2] & w_shift64[15]}},
                w_shift64[15:0]};
      default:
        w_ld = w_shift64[31:0];
    endcase
  end

  assign w_resp = (r_state == RESP);

  assign req.req_ready  = (r_state == IDLE);
  assign req.resp_valid = w_resp;
  assign req.resp_fault = w_resp && r_fault;
  assign req.resp_data  = (w_resp && !r_fault && !r_write)
                        ? w_ld : 32'd0;

  // Enables are forced low while reset is held so an
  // interrupted access cannot touch memory that cycle.
  assign bus.bus_address      = r_addr;
  assign bus.bus_byte_enable  = r_be;
  assign bus.bus_write_data   = r_wdata;
  assign bus.bus_read_enable  = r_re && !reset;
  assign bus.bus_write_enable = r_we && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_fault    <= 1'b0;
      r_split    <= 1'b0;
      r_f3       <= 3'd0;
      r_off      <= 2'd0;
      r_hi_addr  <= 32'd0;
      r_hi_be    <= 4'd0;
      r_hi_wdata <= 32'd0;
      r_lo_data  <= 32'd0;
      r_addr     <= 32'd0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_re       <= 1'b0;
      r_we       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req.req_valid) begin
            r_write    <= req.req_write;
            r_f3       <= req.req_funct3;
            r_off      <= w_off;
            r_split    <= w_split;
            r_fault    <= w_fault;
            r_hi_addr  <= w_lo_addr + 32'd4;
            r_hi_be    <= w_mask8[7:4];
            r_hi_wdata <= w_sdata64[63:32];
            if (w_fault) begin
              r_state <= RESP;
            end else begin
              r_state <= ISSUE_LO;
              r_addr  <= w_lo_addr;
              r_be    <= w_mask8[3:0];
              r_wdata <= w_sdata64[31:0];
              r_we    <= req.req_write;
              r_re    <= !req.req_write;
            end
          end
        end
        ISSUE_LO: begin
          if (r_split) begin
            r_state <= ISSUE_HI;
            r_addr  <= r_hi_addr;
            r_be    <= r_hi_be;
            r_wdata <= r_hi_wdata;
          end else begin
            r_state <= RESP;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
          end
        end
        ISSUE_HI: begin
          r_lo_data <= bus.bus_read_data;
          r_state   <= RESP;
          r_be      <= 4'd0;
          r_wdata   <= 32'd0;
          r_we      <= 1'b0;
        end
        RESP: begin
          r_state <= IDLE;
          r_addr  <= 32'd0;
          r_re    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's memory pipeline stage and `example_data_memory_bus`, turning RV32I load/store requests into aligned word accesses on the bus. Generates byte enables and lane-shifted store data, and splits misaligned halfword/word accesses into two bus accesses. Merges, shifts and sign/zero-extends load data. Range or encoding errors are reported as faults without touching memory.

## Interface
- `DATA_BEGIN`, default `` `DATA_BEGIN ``: lowest valid byte address (inclusive).
- `DATA_END`, default `` `DATA_END ``: highest valid byte address (inclusive).
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (size/sign).
- `req_address`  in  32  byte address.
- `req_store_data`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_data`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  access rejected; qualified by `resp_valid`.
- `bus_address`  out  32  word-aligned address (bits [1:0] = 0).
- `bus_read_data`  in  32  bus read word; valid the cycle after the address is issued, only while read enable is still high.
- `bus_write_data`  out  32  lane-shifted store data.
- `bus_byte_enable`  out  4  byte lanes.
- `bus_read_enable`  out  1
- `bus_write_enable`  out  1

## Operation
- Accept on `req_valid && req_ready`; register write, funct3, address, store data.
- Size: funct3[1:0] 00 = 1, 01 = 2, 10 = 4 bytes.
- Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
- Fault when any of:
  - funct3 is illegal;
  - `address + size - 1` overflows 32 bits;
  - any byte of the access lies outside [DATA_BEGIN, DATA_END].
- On fault: no bus enables at any time; go directly to RESP with `resp_fault=1`, `resp_data=0`.
- Let offset = address[1:0].
  - Split when offset + size > 4.
  - Low word = address & ~3; high word = low + 4.
  - Mask m = ((1<<size)-1) << offset, 8 bits. Low access uses m[3:0]; high access uses m[7:4].
  - Store data: low word = data << 8*offset; high word = data >> 8*(4-offset).
- Load merge: form the 64-bit value {hi, lo} (hi = 0 if not split), shift right by 8*offset, take size bytes. funct3[2] = 0 sign-extends, 1 zero-extends.
- States and transitions:
  - IDLE → ISSUE_LO on accept (RESP on fault).
  - ISSUE_LO → ISSUE_HI if split, else RESP.
  - ISSUE_HI → RESP.
  - RESP → IDLE.
- Bus behaviour:
  - ISSUE_LO and ISSUE_HI drive their word address and byte enables.
  - Write enable is asserted only in ISSUE states.
  - For loads, read enable is high in ISSUE states and in RESP.
  - In RESP, `bus_address` holds the last issued word so `bus_read_data` stays valid.
  - ISSUE_HI captures the low word from `bus_read_data`.
  - RESP combines the captured low word (if split) with the current `bus_read_data`.
- Stores respond in RESP with `resp_data=0` and `resp_fault=0`.

## Timing
- Accept at cycle T.
- Unsplit: bus access at T+1, `resp_valid` at T+2.
- Split: bus accesses at T+1 and T+2, `resp_valid` at T+3.
- Fault: `resp_valid` at T+1.
- `req_ready` drops the cycle after accept and is high again the cycle after RESP. Back-to-back peak rate is one access per 3 cycles.
- Reset values: state IDLE; `req_ready` = 1 from the cycle after reset. All other outputs are 0: `resp_valid`, `resp_fault`, `resp_data`, `bus_address`, `bus_write_data`, `bus_byte_enable`, `bus_read_enable`, `bus_write_enable`.
- Reset mid-operation:
  - In-flight request is dropped; no response.
  - All bus enables are 0 in any cycle where `reset` is high.
  - A split store interrupted after ISSUE_LO leaves only the low part written.
- `req_valid` during a non-IDLE state is ignored and the request is not consumed.
- Bus outputs decode from registered state/request only. There is no combinational path from `req_*` to `bus_*`.

## Test plan
Bench parameters: DATA_BEGIN = 32'h1000_0000, DATA_END = 32'h1000_FFFF; memory preloaded.
- SW 32'hDEADBEEF @ 10000004 → T+1: addr 10000004, be 1111, wdata DEADBEEF, write_enable 1; T+2: resp_valid, fault 0.
- LB @ 10000007 with word DEADBEEF → be 1000, resp_data FFFFFFDE. LBU gives 000000DE; LHU @ 10000006 gives 0000DEAD.
- SW 11223344 @ 10000001 (split):
  - T+1: addr 10000000, be 1110, wdata 22334400.
  - T+2: addr 10000004, be 0001, wdata 00000011.
  - T+3: resp. A following LW @ 10000001 returns 11223344 at T+3.
- LH @ 1000FFFF, LW @ 0FFFFFFE, and funct3 011 @ 10000000 each → resp_valid at T+1, fault 1, data 0, no bus enable ever high.
- LW @ FFFFFFFE (overflow) → fault. `req_valid` held high throughout a split load → exactly one accept; next accept the cycle after RESP.
- Reset asserted during ISSUE_HI of a split store → write_enable 0 that cycle; no resp_valid; only low-word bytes are changed; `req_ready` = 1 the next cycle.
